// File: rtl/rom_port_arb_pkg.sv
// Shared types, constants and address helpers for the ROM port arbiter.
// Byte addresses on the DDR side are 28 bits wide and wrap modulo 2^28.
package rom_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    CH_WR  = 2'd0,
    CH_CPU = 2'd1,
    CH_AUX = 2'd2
  } chan_id_t;

  localparam logic [27:0] AUX_BASE = 28'h0800000;
  localparam logic [27:0] HDR_OFS  = 28'h0000200;

  function automatic logic [27:0] wr_byte_addr(input logic [23:0] byte_addr);
    return {4'b0000, byte_addr};
  endfunction

  // CPU word address to DDR byte address, optionally skipping the ROM header.
  function automatic logic [27:0] cpu_byte_addr(input logic [19:0] word_addr,
                                                input logic        skip);
    logic [27:0] ofs_v;
    if (skip) begin
      ofs_v = HDR_OFS;
    end else begin
      ofs_v = 28'h0000000;
    end
    return {5'b00000, word_addr, 3'b000} + ofs_v;
  endfunction

  function automatic logic [27:0] aux_byte_addr(input logic [20:0] word_addr);
    return AUX_BASE + {4'b0000, word_addr, 3'b000};
  endfunction

endpackage

// File: rtl/rom_arb_chan.sv
// One toggle-handshake requester: holds the ack register and flags a pending
// transaction whenever req and ack differ.
module rom_arb_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic done,
  output logic ack,
  output logic pending
);

  logic ack_r;

  // ack flips once for every completed transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
    end else if (done) begin
      ack_r <= ~ack_r;
    end else begin
      ack_r <= ack_r;
    end
  end

  assign ack     = ack_r;
  assign pending = req ^ ack_r;

endmodule

// File: rtl/rom_port_arb.sv
// Arbitrates a loader write channel and two read channels onto a single DDR
// port with one transaction in flight; aux is protected from CPU starvation.
module rom_port_arb
  import rom_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic [23:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        cpu_req,
  output logic        cpu_ack,
  input  logic [19:0] cpu_addr,
  output logic [63:0] cpu_q,
  input  logic        aux_req,
  output logic        aux_ack,
  input  logic [20:0] aux_addr,
  output logic [63:0] aux_q,
  input  logic        hdr_skip,
  output logic [27:0] dd_wraddr,
  output logic [15:0] dd_din,
  output logic        dd_we_req,
  input  logic        dd_we_ack,
  output logic [27:0] dd_rdaddr,
  output logic        dd_rd_req,
  input  logic        dd_rd_ack,
  input  logic [63:0] dd_dout
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t       state_r, state_nx_s;
  chan_id_t         grant_r, grant_s;
  logic             grant_vld_s;
  logic             wr_pend_s, cpu_pend_s, aux_pend_s;
  logic             wr_done_s, cpu_done_s, aux_done_s;
  logic             starve_full_s;
  logic [CNT_W-1:0] starve_cnt_r, starve_nx_s;
  logic             we_req_r, rd_req_r;
  logic [27:0]      wraddr_r, rdaddr_r;
  logic [15:0]      din_r;
  logic [63:0]      cpu_q_r, aux_q_r;

  rom_arb_chan u_wr_chan (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     (wr_req),
    .done    (wr_done_s),
    .ack     (wr_ack),
    .pending (wr_pend_s)
  );

  rom_arb_chan u_cpu_chan (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     (cpu_req),
    .done    (cpu_done_s),
    .ack     (cpu_ack),
    .pending (cpu_pend_s)
  );

  rom_arb_chan u_aux_chan (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     (aux_req),
    .done    (aux_done_s),
    .ack     (aux_ack),
    .pending (aux_pend_s)
  );

  assign starve_full_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

  // Grant decision, completion detection and next state
  always_comb begin
    state_nx_s  = state_r;
    grant_s     = CH_WR;
    grant_vld_s = 1'b0;
    wr_done_s   = 1'b0;
    cpu_done_s  = 1'b0;
    aux_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_pend_s) begin
          grant_vld_s = 1'b1;
          grant_s     = CH_WR;
          state_nx_s  = ST_WR_WAIT;
        end else if (cpu_pend_s && !(aux_pend_s && starve_full_s)) begin
          grant_vld_s = 1'b1;
          grant_s     = CH_CPU;
          state_nx_s  = ST_RD_WAIT;
        end else if (aux_pend_s) begin
          grant_vld_s = 1'b1;
          grant_s     = CH_AUX;
          state_nx_s  = ST_RD_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (dd_we_ack == we_req_r) begin
          wr_done_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (dd_rd_ack == rd_req_r) begin
          cpu_done_s = (grant_r == CH_CPU);
          aux_done_s = (grant_r == CH_AUX);
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts CPU wins while aux waits, saturating at the limit
  always_comb begin
    starve_nx_s = starve_cnt_r;
    if (!aux_pend_s) begin
      starve_nx_s = '0;
    end else if (grant_vld_s && (grant_s == CH_AUX)) begin
      starve_nx_s = '0;
    end else if (grant_vld_s && (grant_s == CH_CPU) && !starve_full_s) begin
      starve_nx_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_nx_s = starve_cnt_r;
    end
  end

  // FSM, grant and starvation state registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      grant_r      <= CH_WR;
      starve_cnt_r <= '0;
    end else begin
      state_r      <= state_nx_s;
      starve_cnt_r <= starve_nx_s;
      if (grant_vld_s) begin
        grant_r <= grant_s;
      end else begin
        grant_r <= grant_r;
      end
    end
  end

  // DDR request side: address/data capture and request toggles at grant
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      we_req_r <= 1'b0;
      rd_req_r <= 1'b0;
      wraddr_r <= 28'h0000000;
      din_r    <= 16'h0000;
      rdaddr_r <= 28'h0000000;
    end else if (grant_vld_s) begin
      case (grant_s)
        CH_WR: begin
          wraddr_r <= wr_byte_addr(wr_addr);
          din_r    <= wr_data;
          we_req_r <= ~we_req_r;
        end
        CH_CPU: begin
          rdaddr_r <= cpu_byte_addr(cpu_addr, hdr_skip);
          rd_req_r <= ~rd_req_r;
        end
        CH_AUX: begin
          rdaddr_r <= aux_byte_addr(aux_addr);
          rd_req_r <= ~rd_req_r;
        end
        default: begin
          rd_req_r <= rd_req_r;
        end
      endcase
    end else begin
      we_req_r <= we_req_r;
      rd_req_r <= rd_req_r;
    end
  end

  // Read data capture; the channel not being completed keeps its last word
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cpu_q_r <= 64'h0;
      aux_q_r <= 64'h0;
    end else if (cpu_done_s) begin
      cpu_q_r <= dd_dout;
    end else if (aux_done_s) begin
      aux_q_r <= dd_dout;
    end else begin
      cpu_q_r <= cpu_q_r;
      aux_q_r <= aux_q_r;
    end
  end

  assign dd_wraddr = wraddr_r;
  assign dd_din    = din_r;
  assign dd_we_req = we_req_r;
  assign dd_rdaddr = rdaddr_r;
  assign dd_rd_req = rd_req_r;
  assign cpu_q     = cpu_q_r;
  assign aux_q     = aux_q_r;

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb: DDR responders, a transaction-level
// expectation model and a per-cycle compare process.
module tb_rom_port_arb;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        wr_req, wr_ack, cpu_req, cpu_ack, aux_req, aux_ack, hdr_skip;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic [19:0] cpu_addr;
  logic [20:0] aux_addr;
  logic [63:0] cpu_q, aux_q, dd_dout;
  logic [27:0] dd_wraddr, dd_rdaddr;
  logic [15:0] dd_din;
  logic        dd_we_req, dd_we_ack, dd_rd_req, dd_rd_ack;

  rom_port_arb #(.STARVE_MAX(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_addr(cpu_addr), .cpu_q(cpu_q),
    .aux_req(aux_req), .aux_ack(aux_ack), .aux_addr(aux_addr), .aux_q(aux_q),
    .hdr_skip(hdr_skip),
    .dd_wraddr(dd_wraddr), .dd_din(dd_din), .dd_we_req(dd_we_req), .dd_we_ack(dd_we_ack),
    .dd_rdaddr(dd_rdaddr), .dd_rd_req(dd_rd_req), .dd_rd_ack(dd_rd_ack), .dd_dout(dd_dout)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [27:0] addr; logic [63:0] data; } rd_ent_t;
  typedef struct { logic [27:0] addr; logic [15:0] data; } wr_ent_t;

  rd_ent_t cpu_exp[$];
  rd_ent_t aux_exp[$];
  wr_ent_t wr_exp[$];
  int      done_order[$];

  int n_checks = 0;
  int n_errors = 0;
  int rd_lat = 5;
  int wr_lat = 3;
  logic [27:0] rd_last_addr, wr_last_addr;
  logic [15:0] wr_last_data;
  logic [63:0] m_cpu_q, m_aux_q;
  logic        p_wr_ack, p_cpu_ack, p_aux_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [27:0] a);
    if (a == 28'h0000280) return 64'h0123456789ABCDEF;
    return {4'hA, a, ~a, 4'h5};
  endfunction

  function automatic logic [27:0] cpu_map(input logic [19:0] w, input logic h);
    logic [27:0] r;
    r = 28'(w) * 28'd8;
    if (h) r = r + 28'd512;
    return r;
  endfunction

  function automatic logic [27:0] aux_map(input logic [20:0] w);
    return 28'd8388608 + 28'(w) * 28'd8;
  endfunction

  // DDR read responder: one request at a time, answers after rd_lat cycles
  initial begin : rd_resp
    int   cnt;
    logic busy;
    logic [63:0] dat;
    dd_rd_ack = 1'b0; dd_dout = 64'h0; busy = 1'b0; cnt = 0; dat = 64'h0;
    rd_last_addr = 28'h0;
    forever begin
      @(posedge CLK); #1;
      if (!RESET_N) begin
        dd_rd_ack = 1'b0; busy = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          dd_dout = dat; dd_rd_ack = ~dd_rd_ack; busy = 1'b0;
        end
      end else if (dd_rd_req != dd_rd_ack) begin
        busy = 1'b1; cnt = rd_lat; rd_last_addr = dd_rdaddr; dat = mem_data(dd_rdaddr);
      end
    end
  end

  // DDR write responder
  initial begin : wr_resp
    int   cnt;
    logic busy;
    dd_we_ack = 1'b0; busy = 1'b0; cnt = 0;
    wr_last_addr = 28'h0; wr_last_data = 16'h0;
    forever begin
      @(posedge CLK); #1;
      if (!RESET_N) begin
        dd_we_ack = 1'b0; busy = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          dd_we_ack = ~dd_we_ack; busy = 1'b0;
        end
      end else if (dd_we_req != dd_we_ack) begin
        busy = 1'b1; cnt = wr_lat; wr_last_addr = dd_wraddr; wr_last_data = dd_din;
      end
    end
  end

  // Compare process: outputs against the transaction model every cycle
  always @(negedge CLK) begin
    if (!RESET_N) begin
      chk("rst_ctrl", {wr_ack, cpu_ack, aux_ack, dd_we_req, dd_rd_req, dd_wraddr, dd_din}, 64'h0);
      chk("rst_rdaddr", 64'(dd_rdaddr), 64'h0);
      chk("rst_cpu_q", cpu_q, 64'h0);
      chk("rst_aux_q", aux_q, 64'h0);
      cpu_exp.delete(); aux_exp.delete(); wr_exp.delete();
      m_cpu_q = 64'h0; m_aux_q = 64'h0;
      p_wr_ack = 1'b0; p_cpu_ack = 1'b0; p_aux_ack = 1'b0;
    end else begin
      if (wr_ack != p_wr_ack) begin
        wr_ent_t e;
        p_wr_ack = wr_ack;
        n_checks++;
        if (wr_exp.size() == 0) begin
          n_errors++;
          $display("FAIL wr_ack_spurious: ack toggled with 0 outstanding, expected >=1");
        end else begin
          e = wr_exp.pop_front();
          chk("wr_ddr_addr", 64'(wr_last_addr), 64'(e.addr));
          chk("wr_ddr_data", 64'(wr_last_data), 64'(e.data));
          done_order.push_back(0);
        end
      end
      if (cpu_ack != p_cpu_ack) begin
        rd_ent_t e;
        p_cpu_ack = cpu_ack;
        n_checks++;
        if (cpu_exp.size() == 0) begin
          n_errors++;
          $display("FAIL cpu_ack_spurious: ack toggled with 0 outstanding, expected >=1");
        end else begin
          e = cpu_exp.pop_front();
          chk("cpu_ddr_addr", 64'(rd_last_addr), 64'(e.addr));
          m_cpu_q = e.data;
          done_order.push_back(1);
        end
      end
      if (aux_ack != p_aux_ack) begin
        rd_ent_t e;
        p_aux_ack = aux_ack;
        n_checks++;
        if (aux_exp.size() == 0) begin
          n_errors++;
          $display("FAIL aux_ack_spurious: ack toggled with 0 outstanding, expected >=1");
        end else begin
          e = aux_exp.pop_front();
          chk("aux_ddr_addr", 64'(rd_last_addr), 64'(e.addr));
          m_aux_q = e.data;
          done_order.push_back(2);
        end
      end
      chk("cpu_q", cpu_q, m_cpu_q);
      chk("aux_q", aux_q, m_aux_q);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic cpu_issue(input logic [19:0] a);
    rd_ent_t e;
    e.addr = cpu_map(a, hdr_skip); e.data = mem_data(e.addr);
    cpu_exp.push_back(e);
    cpu_addr = a; cpu_req = ~cpu_req;
  endtask

  task automatic aux_issue(input logic [20:0] a);
    rd_ent_t e;
    e.addr = aux_map(a); e.data = mem_data(e.addr);
    aux_exp.push_back(e);
    aux_addr = a; aux_req = ~aux_req;
  endtask

  task automatic wr_issue(input logic [23:0] a, input logic [15:0] d);
    wr_ent_t e;
    e.addr = 28'(a); e.data = d;
    wr_exp.push_back(e);
    wr_addr = a; wr_data = d; wr_req = ~wr_req;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((cpu_exp.size() + aux_exp.size() + wr_exp.size()) != 0 && g < 500) begin
      tick(); g++;
    end
    n_checks++;
    if (g >= 500) begin
      n_errors++;
      $display("FAIL %s_timeout: transactions still outstanding after %0d cycles, expected 0", name, g);
    end
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int   n, ncpu, g;
    logic c0, a0;
    RESET_N = 1'b0; wr_req = 1'b0; cpu_req = 1'b0; aux_req = 1'b0; hdr_skip = 1'b0;
    wr_addr = 24'h0; wr_data = 16'h0; cpu_addr = 20'h0; aux_addr = 21'h0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    chk("post_reset_cpu_ack", 64'(cpu_ack), 64'h0);
    chk("post_reset_rdaddr", 64'(dd_rdaddr), 64'h0);

    // single CPU read with header skip, fixed latency
    hdr_skip = 1'b1; rd_lat = 5;
    c0 = cpu_ack;
    cpu_issue(20'h00010);
    n = 0;
    while (cpu_ack == c0 && n < 50) begin tick(); n++; end
    chk("cpu_latency", 64'(n), 64'd7);
    chk("cpu_rdaddr_lit", 64'(rd_last_addr), 64'h0000280);
    chk("cpu_q_lit", cpu_q, 64'h0123456789ABCDEF);
    wait_idle("cpu_single");

    // CPU read without header skip
    hdr_skip = 1'b0;
    cpu_issue(20'h12345);
    wait_idle("cpu_nohdr");
    chk("cpu_nohdr_lit", 64'(rd_last_addr), 64'h0091A28);

    // loader write
    wr_issue(24'hABCDEF, 16'h1234);
    wait_idle("wr_single");
    chk("wr_addr_lit", 64'(wr_last_addr), 64'h0ABCDEF);
    chk("wr_data_lit", 64'(wr_last_data), 64'h1234);

    // all three channels at once resolve wr, cpu, aux
    done_order.delete();
    wr_issue(24'h000100, 16'hBEEF);
    cpu_issue(20'h00300);
    aux_issue(21'h000040);
    wait_idle("simul");
    chk("simul_count", 64'(done_order.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("simul_order", (i < done_order.size()) ? 64'(done_order[i]) : 64'd99, 64'(i));

    // aux at top of its address range; cpu_q must hold
    aux_issue(21'h1FFFFF);
    wait_idle("aux_max");
    chk("aux_rdaddr_lit", 64'(rd_last_addr), 64'h17FFFF8);
    chk("aux_q_max", aux_q, mem_data(28'h17FFFF8));
    chk("cpu_q_hold", cpu_q, mem_data(cpu_map(20'h00300, 1'b0)));

    // continuous CPU traffic with aux pending: aux wins after 8 CPU grants
    rd_lat = 2;
    done_order.delete();
    cpu_issue(20'h00001);
    aux_issue(21'h000123);
    ncpu = 0; c0 = cpu_ack; a0 = aux_ack; g = 0;
    while (aux_ack == a0 && g < 2000) begin
      tick(); g++;
      if (cpu_ack != c0) begin
        c0 = cpu_ack; ncpu++;
        if (aux_ack == a0) cpu_issue(20'(ncpu + 2));
      end
    end
    chk("starve_cpu_grants", 64'(ncpu), 64'd8);
    wait_idle("starve");
    chk("starve_cnt_clear", 64'(dut.starve_cnt_r), 64'h0);

    // reset while a read is in flight
    rd_lat = 20; hdr_skip = 1'b1;
    c0 = cpu_ack;
    cpu_issue(20'h00040);
    repeat (4) tick();
    chk("mid_inflight", 64'(dd_rd_req ^ dd_rd_ack), 64'h1);
    chk("mid_no_ack", 64'(cpu_ack), 64'(c0));
    #2;
    RESET_N = 1'b0; wr_req = 1'b0; cpu_req = 1'b0; aux_req = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    chk("after_rst_ack", 64'({wr_ack, cpu_ack, aux_ack}), 64'h0);
    chk("after_rst_cpu_q", cpu_q, 64'h0);
    rd_lat = 5;
    cpu_issue(20'h00020);
    wait_idle("after_rst");
    chk("after_rst_rdaddr", 64'(rd_last_addr), 64'h0000300);
    chk("after_rst_ack_final", 64'(cpu_ack), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
